control_unit_mc: RTL and testbench

Multi-cycle RV32I control unit with an optional M-extension mode. It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. Instruction and data memory accesses use ready handshakes, multiply/divide uses a start/done handshake, and illegal instructions are trapped. It sits between the instruction register and the shared-ALU multi-cycle datapath and also provides a retired-instruction counter.

---
 rtl/control_unit_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I(+M) control unit: sequences fetch/decode/exec/mem/wb over
// ready/done handshakes, traps illegal and system instructions, counts retires.
module control_unit_mc #(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_mdu_done,
  input  logic             i_branch_true,
  output logic             o_imem_req,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic [1:0]       o_alu_src_a,
  output logic             o_alu_src_b,
  output logic [3:0]       o_alu_ctrl,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [2:0]       o_mem_size,
  output logic             o_reg_write,
  output logic [1:0]       o_mem_to_reg,
  output logic             o_mdu_start,
  output logic [2:0]       o_mdu_op,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_instret,
  output logic [2:0]       o_state
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_M       = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5,
    S_TRAP     = 3'd6
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic [6:0]       w_opc, w_f7;
  logic [2:0]       w_f3;
  logic             w_is_m, w_illegal;
  logic [3:0]       w_alu_fn;
  logic             w_unused;

  assign w_opc      = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  assign w_unused   = ^{i_instr[24:15], i_instr[11:7]};
  assign w_is_m     = ENABLE_M && (w_opc == OPC_OP) && (w_f7 == F7_M);
  assign o_mem_size = w_f3;
  assign o_mdu_op   = w_f3;
  assign o_instret  = r_instret;
  assign o_state    = r_state;

  // Legality check; SYSTEM (ECALL/EBREAK) falls into the unknown-opcode trap
  always_comb begin
    w_illegal = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: w_illegal = 1'b0;
      OPC_JALR:   w_illegal = (w_f3 != 3'b000);
      OPC_BRANCH: w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      OPC_LOAD:   w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      OPC_STORE:  w_illegal = (w_f3 >= 3'b011);
      OPC_OPIMM: begin
        if (w_f3 == 3'b001)      w_illegal = (w_f7 != F7_BASE);
        else if (w_f3 == 3'b101) w_illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE)     w_illegal = 1'b0;
        else if (w_f7 == F7_ALT) w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
        else if (w_f7 == F7_M)   w_illegal = !ENABLE_M;
        else                     w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_fn = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_fn = ((w_opc == OPC_OP) && i_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_fn = ALU_SLL;
      3'b010:  w_alu_fn = ALU_SLT;
      3'b011:  w_alu_fn = ALU_SLTU;
      3'b100:  w_alu_fn = ALU_XOR;
      3'b101:  w_alu_fn = i_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_fn = ALU_OR;
      default: w_alu_fn = ALU_AND;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  // Next state and strobes; everything stays quiet while reset is held
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    o_imem_req   = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'd0;
    o_alu_src_a  = 2'd0;
    o_alu_src_b  = 1'b0;
    o_alu_ctrl   = ALU_ADD;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 2'd0;
    o_mdu_start  = 1'b0;
    o_trap       = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            w_next     = S_DECODE;
          end
        end
        S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (w_opc)
            OPC_OP: begin
              if (w_is_m) begin
                o_mdu_start = 1'b1;
                w_next      = S_MDU_WAIT;
              end else begin
                o_alu_ctrl = w_alu_fn;
                w_next     = S_WB;
              end
            end
            OPC_OPIMM: begin
              o_alu_src_b = 1'b1;
              o_alu_ctrl  = w_alu_fn;
              w_next      = S_WB;
            end
            OPC_LUI: begin
              o_alu_src_a = 2'd2;
              o_alu_src_b = 1'b1;
              w_next      = S_WB;
            end
            OPC_AUIPC: begin
              o_alu_src_a = 2'd1;
              o_alu_src_b = 1'b1;
              w_next      = S_WB;
            end
            OPC_LOAD, OPC_STORE: begin
              o_alu_src_b = 1'b1;
              w_next      = S_MEM;
            end
            OPC_BRANCH: begin
              o_pc_write = i_branch_true;
              o_pc_src   = 2'd1;
              w_retire   = 1'b1;
              w_next     = S_FETCH;
            end
            OPC_JAL: begin
              o_pc_write = 1'b1;
              o_pc_src   = 2'd1;
              w_next     = S_WB;
            end
            OPC_JALR: begin
              o_alu_src_b = 1'b1;
              o_pc_write  = 1'b1;
              o_pc_src    = 2'd2;
              w_next      = S_WB;
            end
            OPC_FENCE: begin
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
            default: w_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = (w_opc == OPC_STORE);
          if (i_dmem_ready) begin
            w_retire = (w_opc == OPC_STORE);
            w_next   = (w_opc == OPC_STORE) ? S_FETCH : S_WB;
          end
        end
        S_MDU_WAIT: if (i_mdu_done) w_next = S_WB;
        S_WB: begin
          o_reg_write = 1'b1;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
          case (w_opc)
            OPC_LOAD:          o_mem_to_reg = 2'd1;
            OPC_JAL, OPC_JALR: o_mem_to_reg = 2'd2;
            OPC_OP:            o_mem_to_reg = w_is_m ? 2'd3 : 2'd0;
            default:           o_mem_to_reg = 2'd0;
          endcase
        end
        S_TRAP:  o_trap = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: per-instruction expected cycle schedules built from
// instruction class and wait counts, random and directed instruction streams.
module tb_control_unit_mc;

  localparam int unsigned CW = 4;
  localparam int K_ILL = 0, K_OP = 1, K_OPI = 2, K_LUI = 3, K_AUIPC = 4, K_LOAD = 5,
                 K_STORE = 6, K_BR = 7, K_JAL = 8, K_JALR = 9, K_FENCE = 10, K_MUL = 11;
  localparam logic [7:0] SB_IMEM = 8'h80, SB_IR = 8'h40, SB_PC = 8'h20, SB_DREQ = 8'h10,
                         SB_DWE = 8'h08, SB_RW = 8'h04, SB_MS = 8'h02, SB_TRAP = 8'h01;
  localparam logic [31:0] I_ADD = 32'h002081B3;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  st;
    logic [7:0]  strb;
    logic        imem_r, dmem_r, mdu_d, bt;
    bit          chk_pc;  logic [1:0] pc_src;
    bit          chk_m2r; logic [1:0] m2r;
    bit          chk_alu; logic [1:0] a; logic b; logic [3:0] ctrl;
    bit          chk_f3;
    bit          chk_cnt;
  } step_t;

  logic        clk = 1'b0;
  logic        rst, sel_nm, rst_m, rst_n;
  logic        imem_ready, dmem_ready, mdu_done, branch_true;
  logic [31:0] instr;

  logic m_imem_req, m_ir_write, m_pc_write, m_b, m_dreq, m_dwe, m_rw, m_ms, m_trap;
  logic [1:0] m_pc_src, m_a, m_m2r;
  logic [3:0] m_ctrl;
  logic [2:0] m_msize, m_mop, m_state;
  logic [CW-1:0] m_instret;
  logic n_imem_req, n_ir_write, n_pc_write, n_b, n_dreq, n_dwe, n_rw, n_ms, n_trap;
  logic [1:0] n_pc_src, n_a, n_m2r;
  logic [3:0] n_ctrl;
  logic [2:0] n_msize, n_mop, n_state;
  logic [31:0] n_instret;

  logic [2:0]  o_st, o_msize, o_mop;
  logic [7:0]  o_strb;
  logic [1:0]  o_pcsrc, o_m2r, o_a;
  logic        o_b;
  logic [3:0]  o_ctrl;
  logic [31:0] o_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt      = 0;
  step_t q[$];
  logic [31:0] ills [0:9] = '{32'hFFFFFFFF, 32'h00000073, 32'h00100073, 32'h40001033,
                              32'h0000B103, 32'h0000B023, 32'h00002063, 32'h00001067,
                              32'h02009093, 32'h002081B2};

  always #5 clk = ~clk;
  assign rst_m = rst | sel_nm;
  assign rst_n = rst | ~sel_nm;

  control_unit_mc #(.ENABLE_M(1'b1), .CNT_W(CW)) dut_m (
    .i_clk(clk), .i_rst(rst_m), .i_instr(instr), .i_imem_ready(imem_ready),
    .i_dmem_ready(dmem_ready), .i_mdu_done(mdu_done), .i_branch_true(branch_true),
    .o_imem_req(m_imem_req), .o_ir_write(m_ir_write), .o_pc_write(m_pc_write),
    .o_pc_src(m_pc_src), .o_alu_src_a(m_a), .o_alu_src_b(m_b), .o_alu_ctrl(m_ctrl),
    .o_dmem_req(m_dreq), .o_dmem_we(m_dwe), .o_mem_size(m_msize), .o_reg_write(m_rw),
    .o_mem_to_reg(m_m2r), .o_mdu_start(m_ms), .o_mdu_op(m_mop), .o_trap(m_trap),
    .o_instret(m_instret), .o_state(m_state));

  control_unit_mc #(.ENABLE_M(1'b0), .CNT_W(32)) dut_nm (
    .i_clk(clk), .i_rst(rst_n), .i_instr(instr), .i_imem_ready(imem_ready),
    .i_dmem_ready(dmem_ready), .i_mdu_done(mdu_done), .i_branch_true(branch_true),
    .o_imem_req(n_imem_req), .o_ir_write(n_ir_write), .o_pc_write(n_pc_write),
    .o_pc_src(n_pc_src), .o_alu_src_a(n_a), .o_alu_src_b(n_b), .o_alu_ctrl(n_ctrl),
    .o_dmem_req(n_dreq), .o_dmem_we(n_dwe), .o_mem_size(n_msize), .o_reg_write(n_rw),
    .o_mem_to_reg(n_m2r), .o_mdu_start(n_ms), .o_mdu_op(n_mop), .o_trap(n_trap),
    .o_instret(n_instret), .o_state(n_state));

  always_comb begin
    if (sel_nm) begin
      o_st = n_state; o_strb = {n_imem_req, n_ir_write, n_pc_write, n_dreq, n_dwe, n_rw, n_ms, n_trap};
      o_pcsrc = n_pc_src; o_m2r = n_m2r; o_a = n_a; o_b = n_b; o_ctrl = n_ctrl;
      o_msize = n_msize; o_mop = n_mop; o_cnt = n_instret;
    end else begin
      o_st = m_state; o_strb = {m_imem_req, m_ir_write, m_pc_write, m_dreq, m_dwe, m_rw, m_ms, m_trap};
      o_pcsrc = m_pc_src; o_m2r = m_m2r; o_a = m_a; o_b = m_b; o_ctrl = m_ctrl;
      o_msize = m_msize; o_mop = m_mop; o_cnt = 32'(m_instret);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h instr=0x%08h", tag, obs, exp, instr);
    end
  endtask

  // Instruction class straight from the RV32I/M encoding tables
  function automatic int kind_of(input logic [31:0] x, input bit em);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = x[14:12];
    f7 = x[31:25];
    case (x[6:0])
      7'h33: begin
        if (f7 == 7'h00) return K_OP;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return K_OP;
        if (f7 == 7'h01 && em) return K_MUL;
        return K_ILL;
      end
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return K_ILL;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_ILL;
        return K_OPI;
      end
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_ILL;
      7'h23: return (f3 < 3'd3) ? K_STORE : K_ILL;
      7'h63: return (f3 inside {3'd2, 3'd3}) ? K_ILL : K_BR;
      7'h6F: return K_JAL;
      7'h67: return (f3 == 3'd0) ? K_JALR : K_ILL;
      7'h0F: return K_FENCE;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_exp(input logic [31:0] x);
    logic [31:0] tbl;
    logic [3:0]  r;
    tbl = 32'h98654320;
    r = tbl[4*int'(x[14:12]) +: 4];
    if (x[30] && x[14:12] == 3'd5) r = 4'd7;
    if (x[30] && x[14:12] == 3'd0 && x[6:0] == 7'h33) r = 4'd1;
    return r;
  endfunction

  function automatic step_t mk(input logic [31:0] in, input logic [2:0] st, input logic [7:0] strb);
    step_t s;
    s.ins = in; s.st = st; s.strb = strb;
    s.imem_r = 1'($urandom); s.dmem_r = 1'($urandom); s.mdu_d = 1'($urandom); s.bt = 1'($urandom);
    s.chk_pc = 1'b0; s.pc_src = 2'd0; s.chk_m2r = 1'b0; s.m2r = 2'd0;
    s.chk_alu = 1'b0; s.a = 2'd0; s.b = 1'b0; s.ctrl = 4'd0; s.chk_f3 = 1'b0; s.chk_cnt = 1'b0;
    return s;
  endfunction

  // Expected cycle-by-cycle schedule for one instruction; ret = instructions retired
  task automatic plan(input logic [31:0] in, input bit em, input int iw, input int dw,
                      input int mw, input bit bt, output int ret);
    step_t s;
    int k;
    k = kind_of(in, em);
    ret = 1;
    for (int i = 0; i < iw; i++) begin
      s = mk(in, 3'd0, SB_IMEM); s.imem_r = 1'b0; s.chk_cnt = (i == 0); q.push_back(s);
    end
    s = mk(in, 3'd0, SB_IMEM | SB_IR | SB_PC); s.imem_r = 1'b1; s.chk_pc = 1'b1; s.chk_cnt = (iw == 0);
    q.push_back(s);
    q.push_back(mk(in, 3'd1, 8'h00));
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++) begin s = mk(in, 3'd6, SB_TRAP); s.chk_cnt = 1'b1; q.push_back(s); end
      ret = 0;
      return;
    end
    s = mk(in, 3'd2, 8'h00);
    case (k)
      K_OP:    begin s.chk_alu = 1'b1; s.ctrl = alu_exp(in); end
      K_OPI:   begin s.chk_alu = 1'b1; s.b = 1'b1; s.ctrl = alu_exp(in); end
      K_LUI:   begin s.chk_alu = 1'b1; s.a = 2'd2; s.b = 1'b1; end
      K_AUIPC: begin s.chk_alu = 1'b1; s.a = 2'd1; s.b = 1'b1; end
      K_LOAD, K_STORE: begin s.chk_alu = 1'b1; s.b = 1'b1; end
      K_JALR:  begin s.chk_alu = 1'b1; s.b = 1'b1; s.strb = SB_PC; s.chk_pc = 1'b1; s.pc_src = 2'd2; end
      K_JAL:   begin s.strb = SB_PC; s.chk_pc = 1'b1; s.pc_src = 2'd1; end
      K_BR:    begin s.bt = bt; s.strb = bt ? SB_PC : 8'h00; s.chk_pc = bt; s.pc_src = 2'd1; end
      K_MUL:   begin s.strb = SB_MS; s.chk_f3 = 1'b1; end
      default: ;
    endcase
    q.push_back(s);
    if (k == K_BR || k == K_FENCE) return;
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= dw; i++) begin
        s = mk(in, 3'd3, SB_DREQ | ((k == K_STORE) ? SB_DWE : 8'h00));
        s.dmem_r = (i == dw); s.chk_f3 = 1'b1; q.push_back(s);
      end
      if (k == K_STORE) return;
    end
    if (k == K_MUL)
      for (int i = 1; i <= mw; i++) begin s = mk(in, 3'd5, 8'h00); s.mdu_d = (i == mw); q.push_back(s); end
    s = mk(in, 3'd4, SB_RW); s.chk_m2r = 1'b1;
    s.m2r = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_MUL) ? 2'd3 : 2'd0;
    q.push_back(s);
  endtask

  task automatic run(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clk);
      instr = s.ins; imem_ready = s.imem_r; dmem_ready = s.dmem_r; mdu_done = s.mdu_d; branch_true = s.bt;
      #1;
      chk("state_strobes", 32'({o_st, o_strb}), 32'({s.st, s.strb}));
      if (s.chk_pc)  chk("pc_src", 32'(o_pcsrc), 32'(s.pc_src));
      if (s.chk_m2r) chk("mem_to_reg", 32'(o_m2r), 32'(s.m2r));
      if (s.chk_alu) chk("alu_sel", 32'({o_a, o_b, o_ctrl}), 32'({s.a, s.b, s.ctrl}));
      if (s.chk_f3)  chk("funct3_out", 32'((s.st == 3'd3) ? o_msize : o_mop), 32'(s.ins[14:12]));
      if (s.chk_cnt) chk("instret", o_cnt, 32'(cnt) & (sel_nm ? 32'hFFFFFFFF : 32'h0000000F));
    end
    q.delete();
  endtask

  task automatic exec(input logic [31:0] in, input int iw, input int dw, input int mw, input bit bt);
    int r;
    plan(in, !sel_nm, iw, dw, mw, bt, r);
    run(q.size());
    cnt += r;
  endtask

  task automatic idle_chk();
    step_t s;
    s = mk(instr, 3'd0, SB_IMEM); s.imem_r = 1'b0; s.chk_cnt = 1'b1;
    q.push_back(s);
    run(1);
  endtask

  task automatic do_reset(input bit nm);
    @(negedge clk);
    rst = 1'b1; sel_nm = nm; imem_ready = 1'b1; dmem_ready = 1'b1; mdu_done = 1'b1;
    #1;
    chk("reset_strobes", 32'(o_strb), 32'h0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; mdu_done = 1'b0;
    #1;
    chk("post_reset_state", 32'({o_st, o_strb}), 32'({3'd0, SB_IMEM}));
    chk("post_reset_instret", o_cnt, 32'h0);
    cnt = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    logic [14:0] lt;
    logic [17:0] bt;
    lt = {3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
    bt = {3'd7, 3'd6, 3'd5, 3'd4, 3'd1, 3'd0};
    x = $urandom;
    case ($urandom_range(0, 10))
      0: begin
        x[31:25] = ((x[14:12] == 3'd0 || x[14:12] == 3'd5) && x[0]) ? 7'h20 : 7'h00;
        x[6:0] = 7'h33;
      end
      1: begin
        if (x[14:12] == 3'd1) x[31:25] = 7'h00;
        else if (x[14:12] == 3'd5) x[31:25] = x[0] ? 7'h20 : 7'h00;
        x[6:0] = 7'h13;
      end
      2: x[6:0] = 7'h37;
      3: x[6:0] = 7'h17;
      4: begin x[14:12] = lt[3*$urandom_range(0, 4) +: 3]; x[6:0] = 7'h03; end
      5: begin x[14:12] = 3'($urandom_range(0, 2)); x[6:0] = 7'h23; end
      6: begin x[14:12] = bt[3*$urandom_range(0, 5) +: 3]; x[6:0] = 7'h63; end
      7: x[6:0] = 7'h6F;
      8: begin x[14:12] = 3'd0; x[6:0] = 7'h67; end
      9: x = 32'h0FF0000F;
      default: begin x[31:25] = 7'h01; x[6:0] = 7'h33; end
    endcase
    return x;
  endfunction

  initial begin
    int r;
    rst = 1'b1; sel_nm = 1'b0; instr = 32'h0;
    imem_ready = 1'b0; dmem_ready = 1'b0; mdu_done = 1'b0; branch_true = 1'b0;
    do_reset(1'b0);

    // Directed: ALU, load with data waits, branch both ways, MUL, assorted formats
    exec(I_ADD, 0, 0, 0, 1'b0);
    exec(32'h0000A103, 0, 3, 0, 1'b0);
    exec(32'h00208463, 0, 0, 0, 1'b0);
    exec(32'h00208463, 0, 0, 0, 1'b1);
    exec(32'h02208133, 0, 0, 5, 1'b0);
    exec(32'h40208133, 2, 0, 0, 1'b0);
    exec(32'h4010D093, 0, 0, 0, 1'b0);
    exec(32'h40008093, 1, 0, 0, 1'b0);
    exec(32'h0020A023, 0, 2, 0, 1'b0);
    exec(32'h0080006F, 0, 0, 0, 1'b0);
    exec(32'h000080E7, 0, 0, 0, 1'b0);
    exec(32'h123450B7, 0, 0, 0, 1'b0);
    exec(32'h00001097, 0, 0, 0, 1'b0);
    exec(32'h0FF0000F, 0, 0, 0, 1'b0);

    // Random legal stream with random waits; instret wraps at 16
    for (int i = 0; i < 80; i++)
      exec(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom));
    idle_chk();

    // Exactly 17 retires from reset leaves the 4-bit counter at 1
    do_reset(1'b0);
    repeat (17) exec(I_ADD, 0, 0, 0, 1'b0);
    idle_chk();

    // Illegal and system encodings trap after DECODE and hold until reset
    for (int i = 0; i < 10; i++) begin
      do_reset(1'b0);
      exec(ills[i], 0, 0, 0, 1'b0);
    end

    // Reset during a store's data wait and during an MDU wait
    do_reset(1'b0);
    exec(I_ADD, 0, 0, 0, 1'b0);
    plan(32'h0020A023, 1'b1, 0, 4, 0, 1'b0, r);
    run(6);
    do_reset(1'b0);
    exec(I_ADD, 0, 0, 0, 1'b0);
    plan(32'h02208133, 1'b1, 0, 0, 6, 1'b0, r);
    run(5);
    do_reset(1'b0);

    // Without the M extension a MUL encoding traps and does not retire
    do_reset(1'b1);
    exec(I_ADD, 0, 0, 0, 1'b0);
    exec(32'h40208133, 0, 0, 0, 1'b0);
    exec(32'h02208133, 0, 0, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
